// File: rtl/cp0_exception_ctrl.sv
// CP0 for the P7 pipeline (MEM stage): SR/Cause/EPC/PRId,
// interrupt and exception request, mfc0/mtc0 and eret EPC supply.
module cp0_exception_ctrl #(
  parameter logic [31:0] EBASE = 32'h00004180,
  parameter logic [31:0] PRID  = 32'h20221103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] CP0In,
  input  logic        en,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        req,
  output logic [31:0] EBase
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        sr_w;
  logic        epc_w;
  logic [31:0] sr;
  logic [31:0] cause;
  logic        unused_ok;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign req     = int_req | exc_req;

  assign sr    = {16'd0, im, 8'd0, exl, ie};
  assign cause = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

  // eret clears EXL, so a same-cycle SR write would fight it
  assign sr_w  = en & (A2 == 5'd12) & ~req & ~EXLClr;
  assign epc_w = en & (A2 == 5'd14) & ~req;

  assign unused_ok = ^{CP0In[31:16], CP0In[9:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (EXLClr) begin
          exl <= 1'b0;
        end
        if (sr_w) begin
          im  <= CP0In[15:10];
          exl <= CP0In[1];
          ie  <= CP0In[0];
        end
        if (epc_w) begin
          epc <= CP0In;
        end
      end
    end
  end

  always_comb begin
    CP0Out = 32'd0;
    case (A1)
      5'd12:   CP0Out = sr;
      5'd13:   CP0Out = cause;
      5'd14:   CP0Out = epc;
      5'd15:   CP0Out = PRID;
      default: CP0Out = 32'd0;
    endcase
  end

  // forward a same-cycle mtc0 EPC so a back-to-back eret sees it
  assign EPCOut = epc_w ? CP0In : epc;
  assign EBase  = EBASE;

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Coprocessor-0 block of the P7 pipeline, located in the MEM stage.
- Holds SR, Cause, EPC and PRId.
- Detects hardware interrupts and the synchronous exception code carried down the pipe.
- Raises the single-cycle `req` flush pulse and supplies `EBase`; every pipeline register uses these to clear itself and redirect PC to the handler.
- Also serves mfc0/mtc0 and supplies EPC for eret.

Parameters:
- EBASE, 32'h00004180, handler entry address driven on EBase.
- PRID, 32'h20221103, read-only processor ID returned for CP0 register 15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- CP0In  in  32  mtc0 write data
- en  in  1  mtc0 write enable (M-stage mtc0)
- VPC  in  32  PC of the instruction currently in M stage
- BDIn  in  1  M-stage instruction sits in a branch delay slot
- ExcCodeIn  in  5  M-stage synchronous exception code, 0 = none
- HWInt  in  6  external interrupt lines
- EXLClr  in  1  eret in M stage
- CP0Out  out  32  mfc0 read data
- EPCOut  out  32  EPC value for eret redirect
- req  out  1  exception/interrupt request: flush all pipeline registers, PC <= EBase
- EBase  out  32  equals EBASE

Behaviour:

Reset state (async, active-high): SR, Cause and EPC are 0. Therefore req=0, CP0Out=0 for every A1 except 15, EPCOut=0, EBase=EBASE.

Register fields:
- SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
- EPC(14): 32 bits.
- PRId(15): constant PRID.

Request logic (combinational from current register state and inputs):
- IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- req = IntReq | ExcReq.
- Interrupt has priority over exception when both are present.

Posedge update, highest priority first:
1. req=1:
   - EXL <= 1
   - ExcCode <= IntReq ? 0 : ExcCodeIn
   - BD <= BDIn
   - EPC <= BDIn ? (VPC - 4) : VPC
   - A concurrent mtc0 (en=1) or EXLClr is discarded.
2. else EXLClr=1: EXL <= 0. A concurrent mtc0 to SR is discarded; mtc0 to EPC still applies.
3. else en=1:
   - A2=12 writes SR bits [15:10], [1], [0] only.
   - A2=14 writes EPC.
   - A2=13, A2=15 and any other number are ignored.

Cause.IP:
- Cause.IP <= HWInt on every clock edge, independent of req/en.
- Cause.IP is not writable by mtc0.

Read ports:
- CP0Out is a combinational mux on A1: 12/13/14/15 return the fields above; any other A1 returns 0. There is no write-to-read bypass.
- EPCOut = (en & A2==14 & ~req) ? CP0In : EPC. This bypass lets an eret issued right after an mtc0 EPC use the new value.

Timing:
- req is a level, but it de-asserts in the cycle after it is taken, because EXL becomes 1.
- Nested exceptions are masked while EXL=1.
- Reset asserted mid-operation clears state immediately, without waiting for clk; req drops in the same delta.
- VPC arithmetic is 32-bit modular.

Test Plan:
1. Reset, then mtc0 A2=12 CP0In=32'h0000_FC01, then HWInt=6'b000100 -> req=1 for exactly one cycle; afterwards SR=32'h0000_FC03, Cause.ExcCode=0, Cause.IP=6'b000100, EPC=VPC (e.g. 32'h0000_3010).
2. IE=0 or IM=0 with HWInt=6'h3F -> req stays 0; Cause reads 32'h0000_FC00 (IP mirrors HWInt).
3. ExcCodeIn=5'd12 (Ov), BDIn=1, VPC=32'h0000_3024, SR.EXL=0 -> req=1; next cycle EPC=32'h0000_3020, Cause=32'h8000_0030, EXL=1.
4. EXL=1 and ExcCodeIn=4 -> req=0 and EPC unchanged. EXLClr pulse -> EXL=0. Keep ExcCodeIn=4 -> req=1 again.
5. Same cycle en=1, A2=14, CP0In=32'h0000_5000 -> EPCOut=32'h0000_5000 combinationally. If req=1 in that cycle, the EPC write is dropped and EPCOut shows the old EPC.
6. req and EXLClr together -> EXL stays 1 and the ExcCode is captured. Assert reset asynchronously mid-cycle -> SR/Cause/EPC read 0 and req=0 before the next clk edge.
